// File: rtl/ram16x2_pkg.sv
// Shared types and constants for the 16x2 RAM read sequencer.
// Holds the FSM state encoding, RAM geometry and the length clamp helper.
package ram16x2_pkg;

   localparam int RAM_DEPTH = 16;
   localparam int RAM_AW    = 4;
   localparam int RAM_DW    = 2;
   localparam int CNT_W     = 5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      READ = 3'd2,
      EMIT = 3'd3,
      FIN  = 3'd4
   } state_t;

   // Requests longer than the RAM simply read the whole array once.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
      return (len > CNT_W'(RAM_DEPTH)) ? CNT_W'(RAM_DEPTH) : len;
   endfunction

endpackage

// File: rtl/ram16x2_pack.sv
// Slot register that gathers consecutive 2-bit RAM words into one output beat.
// Word k of a beat lands in bits [2k+1:2k]; unwritten slots stay 0 after a clear.
module ram16x2_pack
   import ram16x2_pkg::*;
#(
   parameter int PACK = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic                     we_i,
   input  logic [RAM_DW-1:0]        wdata_i,
   output logic [$clog2(PACK+1)-1:0] idx_o,
   output logic                     full_o,
   output logic [RAM_DW*PACK-1:0]   data_o
);

   localparam int IW = $clog2(PACK + 1);

   logic [IW-1:0]          idx_q, idx_d;
   logic [RAM_DW*PACK-1:0] data_q, data_d;

   assign full_o = (idx_q == IW'(PACK));
   assign idx_o  = idx_q;
   assign data_o = data_q;

   always_comb begin
      idx_d  = idx_q;
      data_d = data_q;
      if (clr_i) begin
         idx_d  = '0;
         data_d = '0;
      end else if (we_i && !full_o) begin
         for (int s = 0; s < PACK; s++) begin
            if (idx_q == IW'(s)) data_d[s*RAM_DW +: RAM_DW] = wdata_i;
         end
         idx_d = idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         idx_q  <= idx_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/ram16x2_reader.sv
// Read-side sequencer: arbitrates for the RAM address bus, walks a wrapping
// address window and streams packed words out over valid/ready.
module ram16x2_reader
   import ram16x2_pkg::*;
#(
   parameter int PACK = 4
) (
   input  logic                WCLK,
   input  logic                RST_N,
   input  logic                START,
   input  logic [RAM_AW-1:0]   BASE,
   input  logic [CNT_W-1:0]    LEN,
   output logic                BUSY,
   output logic                RAM_REQ,
   input  logic                RAM_GNT,
   output logic [RAM_AW-1:0]   A,
   input  logic [RAM_DW-1:0]   RD,
   output logic                M_VALID,
   input  logic                M_READY,
   output logic [2*PACK-1:0]   M_DATA,
   output logic                M_LAST,
   output logic                DONE,
   output state_t              DBG_STATE
);

   // Stream handshake: a beat transfers on a WCLK edge with M_VALID && M_READY;
   // once M_VALID rises, M_DATA and M_LAST hold until that transfer.

   localparam int IW = $clog2(PACK + 1);

   state_t            state_q;
   logic [RAM_AW-1:0] a_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q, req_q, valid_q, last_q, done_q;

   logic [CNT_W-1:0]  len_c;
   logic [IW-1:0]     pk_idx;
   logic              pk_full, pk_we, pk_clr;
   logic              slot_last, last_word;

   assign len_c     = clamp_len(LEN);
   assign slot_last = (pk_idx == IW'(PACK - 1));
   assign last_word = (cnt_q == CNT_W'(1));

   assign pk_we  = (state_q == READ) && RAM_GNT && !pk_full;
   assign pk_clr = ((state_q == IDLE) && START && (len_c != '0)) ||
                   ((state_q == EMIT) && M_READY);

   ram16x2_pack #(.PACK(PACK)) u_pack (
      .clk_i   (WCLK),
      .rst_ni  (RST_N),
      .clr_i   (pk_clr),
      .we_i    (pk_we),
      .wdata_i (RD),
      .idx_o   (pk_idx),
      .full_o  (pk_full),
      .data_o  (M_DATA)
   );

   always_ff @(posedge WCLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         a_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (START) begin
                  busy_q <= 1'b1;
                  if (len_c == '0) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= REQ;
                     a_q     <= BASE;
                     cnt_q   <= len_c;
                     req_q   <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (RAM_GNT) state_q <= READ;
            end
            // The request stays up through EMIT so the writer cannot slip in between beats.
            READ: begin
               if (RAM_GNT) begin
                  a_q   <= a_q + RAM_AW'(1);
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (slot_last || last_word) begin
                     state_q <= EMIT;
                     valid_q <= 1'b1;
                     last_q  <= last_word;
                  end
               end
            end
            EMIT: begin
               if (M_READY) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (cnt_q == '0) begin
                     state_q <= FIN;
                     done_q  <= 1'b1;
                     req_q   <= 1'b0;
                  end else begin
                     state_q <= READ;
                  end
               end
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY      = busy_q;
   assign RAM_REQ   = req_q;
   assign A         = a_q;
   assign M_VALID   = valid_q;
   assign M_LAST    = last_q;
   assign DONE      = done_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ram16x2_reader.sv
// Directed bench for ram16x2_reader (PACK=4) against a 16x2 RAM preloaded with addr[1:0].
module tb_ram16x2_reader;
   import ram16x2_pkg::*;

   logic       WCLK, RST_N, START, RAM_GNT, M_READY;
   logic [3:0] BASE, A;
   logic [4:0] LEN;
   logic [1:0] RD;
   logic [7:0] M_DATA;
   logic       BUSY, RAM_REQ, M_VALID, M_LAST, DONE;
   state_t     dbg_state;

   logic [1:0] ram [16];
   logic [7:0] exp_q [$];
   int         n_checks, n_fail;

   typedef struct {
      logic [3:0] base;
      logic [4:0] len;
      bit         busy_start;
      int         exp_beats;
      logic [7:0] exp_last;
      int         exp_first;
      int         exp_done;
      logic [3:0] exp_a;
   } vec_t;
   vec_t vecs [8];

   ram16x2_reader #(.PACK(4)) dut (
      .WCLK(WCLK), .RST_N(RST_N), .START(START), .BASE(BASE), .LEN(LEN),
      .BUSY(BUSY), .RAM_REQ(RAM_REQ), .RAM_GNT(RAM_GNT), .A(A), .RD(RD),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_LAST(M_LAST),
      .DONE(DONE), .DBG_STATE(dbg_state)
   );

   assign RD = ram[A];

   initial WCLK = 1'b0;
   always #5 WCLK = ~WCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference packing straight from the RAM contents.
   task automatic push_expected(input logic [3:0] base, input logic [4:0] len);
      int         n, slot;
      logic [7:0] beat;
      logic [3:0] addr;
      n = (len > 5'd16) ? 16 : int'(len);
      beat = '0; slot = 0; addr = base;
      for (int i = 0; i < n; i++) begin
         beat[slot*2 +: 2] = ram[addr];
         addr = addr + 4'd1;
         slot++;
         if (slot == 4 || i == n - 1) begin
            exp_q.push_back(beat);
            beat = '0;
            slot = 0;
         end
      end
   endtask

   task automatic start_txn(input logic [3:0] base, input logic [4:0] len);
      BASE = base; LEN = len; START = 1'b1;
      @(posedge WCLK);
      @(negedge WCLK);
      START = 1'b0;
   endtask

   task automatic wait_valid(input int limit, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge WCLK);
         seen = M_VALID;
      end
      check({name, " valid_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int         beats, first, done_cyc;
      logic [7:0] last_data, exp_b;
      bit         fin;
      beats = 0; first = -1; done_cyc = -1; last_data = '0; fin = 1'b0;
      exp_q.delete();
      push_expected(v.base, v.len);
      start_txn(v.base, v.len);
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         START = (v.busy_start && cyc == 2);
         if (START) begin BASE = 4'd8; LEN = 5'd16; end
         if (M_VALID && first < 0) first = cyc;
         if (M_VALID && M_READY) begin
            beats++;
            last_data = M_DATA;
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL v%0d extra_beat: got data 0x%0h, expected no beat", idx, M_DATA);
            end else begin
               exp_b = exp_q.pop_front();
               check($sformatf("v%0d beat%0d data", idx, beats), 32'(M_DATA), 32'(exp_b));
               check($sformatf("v%0d beat%0d last", idx, beats), 32'(M_LAST), 32'(exp_q.size() == 0));
            end
         end
         if (DONE) begin done_cyc = cyc; fin = 1'b1; end
         if (!fin) @(negedge WCLK);
      end
      START = 1'b0;
      check($sformatf("v%0d done_seen", idx), 32'(fin), 32'd1);
      check($sformatf("v%0d beats", idx), 32'(beats), 32'(v.exp_beats));
      if (v.exp_beats > 0) check($sformatf("v%0d last_data", idx), 32'(last_data), 32'(v.exp_last));
      check($sformatf("v%0d first_valid_cyc", idx), 32'(first), 32'(v.exp_first));
      check($sformatf("v%0d done_cyc", idx), 32'(done_cyc), 32'(v.exp_done));
      check($sformatf("v%0d end_addr", idx), 32'(A), 32'(v.exp_a));
      check($sformatf("v%0d model_drained", idx), 32'(exp_q.size()), 32'd0);
      @(negedge WCLK);
      check($sformatf("v%0d done_pulse_len", idx), 32'(DONE), 32'd0);
      check($sformatf("v%0d busy_after", idx), 32'(BUSY), 32'd0);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      for (int i = 0; i < 16; i++) ram[i] = 2'(i);
      START = 1'b0; BASE = '0; LEN = '0; RAM_GNT = 1'b1; M_READY = 1'b1;
      RST_N = 1'b1;

      // base, len, busy_start, beats, last beat, first valid cycle, DONE cycle, final A
      vecs[0] = '{4'd0,  5'd16, 1'b0, 4, 8'hE4,  5, 21, 4'd0};
      vecs[1] = '{4'd14, 5'd4,  1'b0, 1, 8'h4E,  5,  6, 4'd2};
      vecs[2] = '{4'd1,  5'd5,  1'b0, 2, 8'h01,  5,  8, 4'd6};
      vecs[3] = '{4'd3,  5'd20, 1'b0, 4, 8'h93,  5, 21, 4'd3};
      vecs[4] = '{4'd15, 5'd1,  1'b0, 1, 8'h03,  2,  3, 4'd0};
      vecs[5] = '{4'd5,  5'd7,  1'b0, 2, 8'h39,  5, 10, 4'd12};
      vecs[6] = '{4'd7,  5'd0,  1'b0, 0, 8'h00, -1,  0, 4'd12};
      vecs[7] = '{4'd0,  5'd4,  1'b1, 1, 8'hE4,  5,  6, 4'd4};

      #2 RST_N = 1'b0;
      #1;
      check("reset outputs", {BUSY, RAM_REQ, M_VALID, M_LAST, DONE, A, M_DATA}, '0);
      check("reset state", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(negedge WCLK);
      RST_N = 1'b1;
      @(negedge WCLK);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Back-pressure: beat must hold and the address must not move.
      M_READY = 1'b0;
      start_txn(4'd0, 5'd8);
      wait_valid(20, "stall first");
      for (int i = 0; i < 10; i++) begin
         @(negedge WCLK);
         check($sformatf("stall hold%0d", i), {M_VALID, M_LAST, M_DATA, A}, {1'b1, 1'b0, 8'hE4, 4'd4});
      end
      M_READY = 1'b1;
      wait_valid(20, "stall second");
      check("stall beat2", {M_LAST, M_DATA, A}, {1'b1, 8'hE4, 4'd8});
      @(negedge WCLK);
      check("stall done", 32'(DONE), 32'd1);
      @(negedge WCLK);

      // Grant withheld in REQ, then dropped mid-READ.
      RAM_GNT = 1'b0;
      start_txn(4'd14, 5'd4);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("gnt wait%0d", i), {RAM_REQ, M_VALID, A}, {1'b1, 1'b0, 4'd14});
         @(negedge WCLK);
      end
      RAM_GNT = 1'b1;
      repeat (3) @(negedge WCLK);
      check("gnt two captured", 32'(A), 32'd0);
      RAM_GNT = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge WCLK);
         check($sformatf("gnt drop%0d", i), {RAM_REQ, M_VALID, A}, {1'b1, 1'b0, 4'd0});
      end
      RAM_GNT = 1'b1;
      wait_valid(10, "gnt");
      check("gnt beat", {M_LAST, M_DATA, A}, {1'b1, 8'h4E, 4'd2});
      @(negedge WCLK);
      check("gnt done", 32'(DONE), 32'd1);
      @(negedge WCLK);

      // Asynchronous reset while a beat is waiting.
      M_READY = 1'b0;
      start_txn(4'd0, 5'd16);
      wait_valid(20, "rst");
      #2 RST_N = 1'b0;
      #1;
      check("rst mid-emit outputs", {BUSY, RAM_REQ, M_VALID, M_LAST, DONE, A, M_DATA}, '0);
      @(negedge WCLK);
      check("rst no done", 32'(DONE), 32'd0);
      RST_N = 1'b1;
      M_READY = 1'b1;
      @(negedge WCLK);
      run_vec(vecs[0], 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test end");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram16x2_reader.md
Name: ram16x2_reader

Overview:
Read-side sequencer for a 16x2 distributed RAM whose write port is owned by a separate writer.
- Arbitrates for the shared address bus with a req/gnt pair.
- Walks a programmable address window, wrapping modulo 16.
- Samples the RAM's asynchronous read data and packs consecutive 2-bit words into beats.
- Streams the beats out over a valid/ready interface.
- Sits between the RAM's address/data pins and any downstream consumer, such as a config loader or debug dump.

Parameters:
PACK, 4, 2-bit words per output beat; legal values are 1, 2 and 4; M_DATA width is 2*PACK.

Ports:
WCLK  in  1  clock, shared with the RAM write clock
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle request to begin a readout; sampled only in IDLE
BASE  in  4  first RAM address; captured on START
LEN  in  5  number of words to read, 0..16; values above 16 are treated as 16; captured on START
BUSY  out  1  high in every state except IDLE
RAM_REQ  out  1  bus request to the arbiter shared with the writer
RAM_GNT  in  1  bus grant; while high, A drives the RAM address pins
A  out  4  RAM address, driven onto A3..A0
RD  in  2  RAM read data, {O1,O0}; combinational from A
M_VALID  out  1  output beat valid
M_READY  in  1  downstream ready
M_DATA  out  2*PACK  packed words; the earliest word occupies bits [1:0]
M_LAST  out  1  marks the final beat of the transaction
DONE  out  1  one-cycle pulse when the transaction completes

Behaviour:
- Reset (asynchronous, RST_N=0): state goes to IDLE. BUSY, RAM_REQ, M_VALID, M_LAST and DONE are 0. A, M_DATA, and the internal count and pack index are 0. Reset asserted mid-transaction aborts it immediately, with no DONE and no partial beat.
- FSM states: IDLE, REQ, READ, EMIT, FIN.
- IDLE:
  - START with LEN=0 → FIN (DONE pulses on the next cycle; no beats are emitted).
  - START with LEN≠0 → REQ. BASE is loaded into A; remaining count = min(LEN,16); pack index = 0; pack register cleared.
- REQ: RAM_REQ=1. On the first edge where RAM_GNT=1 → READ.
- READ: RAM_REQ=1 and A is driven.
  - On each edge with RAM_GNT=1: RD is written into pack slot [index]; A increments modulo 16 (address 15 wraps to 0); count decrements; index increments.
  - If RAM_GNT=0: stall. Nothing is captured and A holds.
  - → EMIT when index reaches PACK or count reaches 0.
- EMIT: M_VALID=1. M_DATA holds the pack register, with unfilled slots of a partial final beat reading 0. M_LAST = (count==0).
  - RAM_REQ stays high throughout, so the writer cannot interleave.
  - M_DATA and M_LAST are stable while M_VALID=1 and M_READY=0.
  - On M_VALID&M_READY: if count==0 → FIN; otherwise clear the pack register and index, then → READ.
- FIN: DONE=1 for exactly one cycle; RAM_REQ=0; → IDLE. BUSY drops in the IDLE cycle that follows.
- START is ignored while BUSY=1.
- Latency: with RAM_GNT already high and START sampled at edge 0, REQ is entered after edge 0 and READ after edge 1. The first M_VALID is visible after edge 1+PACK (PACK=4: after edge 5).
- Throughput: one beat per PACK+1 cycles when M_READY is held high.
- Simultaneous events:
  - A RAM_GNT drop during EMIT has no effect; data is already captured.
  - RAM_GNT is sampled only in REQ and READ.

Decomposition:
- Shared package ram16x2_pkg:
  - State enum (IDLE/REQ/READ/EMIT/FIN)
  - RAM_DEPTH=16, RAM_AW=4, RAM_DW=2
  - Function clamp_len(LEN)
- Natural sub-module: ram16x2_pack. This is the PACK-slot shift/pack register with clear, write-enable and index, and outputs full/data. The FSM and address counter stay in the top module.

Test Plan:
- RAM preloaded with addr[1:0] at each address. PACK=4, BASE=0, LEN=16, M_READY=1, GNT=1 → 4 beats of 8'hE4, M_LAST on the 4th beat only, one DONE pulse, A wraps back to 0.
- BASE=14, LEN=4 → addresses 14,15,0,1 read in order; M_DATA={RAM[1],RAM[0],RAM[15],RAM[14]}; M_LAST=1; single beat.
- LEN=5, PACK=4 → two beats; the second beat has data only in bits [1:0] and 0 in bits [7:2], with M_LAST=1.
- M_READY held low for 10 cycles during EMIT → M_VALID, M_DATA and M_LAST stay stable, A does not advance, no extra RD captures occur; the transfer completes after M_READY rises.
- RAM_GNT held 0 for 3 cycles in REQ, then dropped for 2 cycles mid-READ → no captures while GNT=0, A frozen, final data identical to the uninterrupted run.
- Corner cases:
  - LEN=0 → DONE one cycle after START, no M_VALID.
  - START pulsed while BUSY → ignored.
  - RST_N asserted mid-EMIT → all outputs 0 asynchronously; the next START runs a clean transaction.
